dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller forming the MEM stage. It sits between the EX/MEM register and the MEM/WB register. It serves load and store requests from EX/MEM, returns load data that feeds the MEM/WB `data_i`, and raises a stall while a miss is serviced over a line-wide request/acknowledge memory port.

## Interface
- `IDX_W`, default 5: index bits; number of lines is 2^IDX_W.
- `LINE_WORDS`, default 4: 32-bit words per line, power of two; line width is `32*LINE_WORDS`.
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `req_i`, in, 1: access valid (MemRead | MemWrite from EX/MEM).
- `we_i`, in, 1: 1 = store, 0 = load.
- `addr_i`, in, 32: byte address, word-aligned (`addr_i[1:0]` ignored).
- `wdata_i`, in, 32: store data.
- `rdata_o`, out, 32: load data.
- `stall_o`, out, 1: freeze PC, IF/ID, ID/EX and EX/MEM; also inserts a bubble into MEM/WB.
- `mem_req_o`, out, 1: memory request.
- `mem_we_o`, out, 1: 1 = line write-back, 0 = line fetch.
- `mem_addr_o`, out, 32: line-aligned address.
- `mem_wdata_o`, out, `32*LINE_WORDS`: victim line.
- `mem_ack_i`, in, 1: one-cycle completion pulse.
- `mem_rdata_i`, in, `32*LINE_WORDS`: fetched line, valid with `mem_ack_i`.

## Operation
- Address split, with OFF_W = log2(LINE_WORDS):
  - word select is `addr_i[OFF_W+1:2]`;
  - index is `addr_i[OFF_W+1+IDX_W:OFF_W+2]`;
  - tag is the remaining upper bits (TAG_W = 30 - OFF_W - IDX_W).
- Per-line state: valid, dirty, tag, data.
- Hit means `req_i` & valid[index] & tag match.
- `stall_o` = `req_i` & (~hit | state != IDLE). It is combinational.
- `rdata_o` is the selected word when load hit in IDLE, otherwise 0.
- Store hit: the word is written and dirty is set at the posedge. Other words of the line are untouched.
- FSM states:
  - IDLE:
    - hit or no request: stay.
    - miss with valid & dirty victim: go to WRITEBACK.
    - miss otherwise: go to REFILL.
  - WRITEBACK:
    - drives `mem_req_o`=1, `mem_we_o`=1, address {victim tag, index, 0}, and the victim line on `mem_wdata_o`.
    - on `mem_ack_i`: go to REFILL.
  - REFILL:
    - drives `mem_req_o`=1, `mem_we_o`=0, address {req tag, index, 0}.
    - on `mem_ack_i`: capture `mem_rdata_i` into a line buffer and go to FILL.
  - FILL:
    - writes the buffer, tag and valid=1, dirty=0 into the line.
    - then returns to IDLE, where the still-held request now hits. A store completes there as a normal store hit.
- Inputs `req_i`/`we_i`/`addr_i`/`wdata_i` are held stable by the pipeline while `stall_o`=1.
- If `req_i` drops mid-miss, the FSM still completes the current transaction and the fill. No abort.
- Reset (async, any state):
  - state returns to IDLE;
  - all valid and dirty bits clear;
  - `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o` go to 0 immediately;
  - `rdata_o`=0 and `stall_o`=0 while `req_i`=0.
  - An in-flight memory transaction is abandoned; a late `mem_ack_i` in IDLE is ignored.

## Timing
- Hit latency is 0 cycles: data is combinational in the same cycle and `stall_o` stays low.
- Memory handshake rules:
  - `mem_req_o` and its address/data are registered outputs, asserted on the edge that enters WRITEBACK/REFILL;
  - they are held stable until `mem_ack_i` is sampled high, then drop on that same edge.
  - Ack may arrive in the first cycle of request.
- Clean miss cost is 1 (REFILL entry) + memory latency + 1 (FILL) cycles. Dirty miss adds one write-back transaction.
- Minimum clean miss: `stall_o` high for 3 cycles with immediate ack: IDLE-miss, REFILL, FILL. The hit is returned in the 4th.
- The two memory transactions of a dirty miss are back-to-back: `mem_req_o` stays high, `mem_we_o` falls 1→0 at the WRITEBACK→REFILL edge.

## Structure
- Package `dcache_pkg` holds:
  - the state enum (IDLE, WRITEBACK, REFILL, FILL);
  - localparam helpers: OFF_W, TAG_W, LINE_W;
  - the address field-extraction functions.
- Sub-module `dcache_array`: tag/valid/dirty/data storage, with async clear of valid/dirty, combinational read, and a synchronous line write or word write. The FSM and handshake live in `dcache_ctrl`.

## Test plan
- Reset with `rst_i` low for 2 cycles, then load 0x0000_0040:
  - `stall_o`=1 and REFILL requests `mem_addr_o`=0x40, `mem_we_o`=0;
  - ack with line {0x44444444,0x33333333,0x22222222,0x11111111};
  - `rdata_o`=0x11111111 with `stall_o`=0 two cycles later.
- Store 0xDEADBEEF to 0x48 (resident):
  - no stall, no `mem_req_o`;
  - then load 0x48 returns 0xDEADBEEF and load 0x44 returns 0x22222222.
- Conflict load 0x0000_0840 (same index, dirty line):
  - WRITEBACK with `mem_addr_o`=0x40 and word2 of `mem_wdata_o`=0xDEADBEEF;
  - then REFILL with `mem_addr_o`=0x840; `mem_req_o` stays high across the transition.
- Memory ack delayed 5 cycles: `mem_req_o`/`mem_addr_o` stay constant for all 5 cycles and `stall_o` stays high throughout.
- Assert `rst_i` low during REFILL:
  - `mem_req_o`=0 immediately and a later `mem_ack_i` is ignored;
  - a re-access to 0x40 misses again (valid cleared).
- Store miss to 0x100 on a clean line:
  - refill, then the word is written in IDLE and dirty set;
  - an evicting access to 0x900 triggers a write-back containing the store data.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-back data cache.
// Pure declarations: no logic, no latency, no flow control.
// Field helpers take the geometry as arguments so every parameterisation can share them.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        FILL      = 2'd3
    } state_t;

    localparam int IDX_W_DEF      = 5;
    localparam int LINE_WORDS_DEF = 4;
    localparam int OFF_W          = $clog2(LINE_WORDS_DEF);
    localparam int TAG_W          = 30 - OFF_W - IDX_W_DEF;
    localparam int LINE_W         = 32 * LINE_WORDS_DEF;

    function automatic logic [31:0] addr_word(input logic [31:0] addr, input int off_w);
        return (addr >> 2) & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int idx_w,
                                               input int off_w);
        return (addr >> (off_w + 2)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w,
                                             input int off_w);
        return addr >> (off_w + idx_w + 2);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the data cache.
// Reads are combinational; line or word writes land on the next clk_i edge.
// No flow control: the controller never issues both writes in one cycle.
module dcache_array
    import dcache_pkg::*;
#(
    parameter  int IDX_W      = IDX_W_DEF,
    parameter  int LINE_WORDS = LINE_WORDS_DEF,
    localparam int OW         = $clog2(LINE_WORDS),
    localparam int TW         = 30 - OW - IDX_W,
    localparam int LW         = 32 * LINE_WORDS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic             rd_dirty,
    output logic [TW-1:0]    rd_tag,
    output logic [LW-1:0]    rd_line,
    input  logic             line_we,
    input  logic             word_we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TW-1:0]    wr_tag,
    input  logic [LW-1:0]    wr_line,
    input  logic [OW-1:0]    wr_sel,
    input  logic [31:0]      wr_word
);
    localparam int NL = 1 << IDX_W;

    logic [NL-1:0] valid_q;
    logic [NL-1:0] dirty_q;
    logic [TW-1:0] tag_q  [NL];
    logic [LW-1:0] data_q [NL];

    // Only the status bits need reset; tag and data are meaningless while invalid.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end else if (word_we) begin
            data_q[wr_idx][{wr_sel, 5'd0} +: 32] <= wr_word;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage direct-mapped write-back/write-allocate data cache controller.
// Hits return data combinationally (0 cycles); misses cost refill + memory latency + fill.
// Stalls the pipeline during misses; memory port is req/ack with registered, held requests.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter  int IDX_W      = IDX_W_DEF,
    parameter  int LINE_WORDS = LINE_WORDS_DEF,
    localparam int OW         = $clog2(LINE_WORDS),
    localparam int TW         = 30 - OW - IDX_W,
    localparam int LW         = 32 * LINE_WORDS
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o,
    output logic          stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [31:0]   mem_addr_o,
    output logic [LW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [LW-1:0] mem_rdata_i
);
    state_t           state_q, state_d;
    logic [OW-1:0]    req_sel;
    logic [IDX_W-1:0] req_idx, miss_idx_q;
    logic [TW-1:0]    req_tag, miss_tag_q, rd_tag;
    logic             rd_valid, rd_dirty, hit, line_we, word_we;
    logic [LW-1:0]    rd_line, fill_buf_q;

    assign req_sel = OW'(addr_word(addr_i, OW));
    assign req_idx = IDX_W'(addr_index(addr_i, IDX_W, OW));
    assign req_tag = TW'(addr_tag(addr_i, IDX_W, OW));
    assign hit     = req_i & rd_valid & (rd_tag == req_tag);

    dcache_array #(.IDX_W(IDX_W), .LINE_WORDS(LINE_WORDS)) u_array (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .line_we  (line_we),
        .word_we  (word_we),
        .wr_idx   ((state_q == FILL) ? miss_idx_q : req_idx),
        .wr_tag   (miss_tag_q),
        .wr_line  (fill_buf_q),
        .wr_sel   (req_sel),
        .wr_word  (wdata_i)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req_i && !hit) state_d = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
            WRITEBACK: if (mem_ack_i) state_d = REFILL;
            REFILL:    if (mem_ack_i) state_d = FILL;
            FILL:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o = req_i & (~hit | (state_q != IDLE));
        rdata_o = '0;
        word_we = 1'b0;
        line_we = (state_q == FILL);
        if (state_q == IDLE && hit) begin
            if (we_i) word_we = 1'b1;
            else      rdata_o = rd_line[{req_sel, 5'd0} +: 32];
        end
    end

    // The miss address is latched so the fill completes even if the request is withdrawn.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            miss_idx_q  <= '0;
            miss_tag_q  <= '0;
            fill_buf_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (state_d != IDLE) begin
                    miss_idx_q <= req_idx;
                    miss_tag_q <= req_tag;
                    mem_req_o  <= 1'b1;
                    if (state_d == WRITEBACK) begin
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= {rd_tag, req_idx, {(OW+2){1'b0}}};
                        mem_wdata_o <= rd_line;
                    end else begin
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= {req_tag, req_idx, {(OW+2){1'b0}}};
                    end
                end
                WRITEBACK: if (mem_ack_i) begin
                    mem_we_o    <= 1'b0;
                    mem_addr_o  <= {miss_tag_q, miss_idx_q, {(OW+2){1'b0}}};
                    mem_wdata_o <= '0;
                end
                REFILL: if (mem_ack_i) begin
                    mem_req_o  <= 1'b0;
                    mem_addr_o <= '0;
                    fill_buf_q <= mem_rdata_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomised scoreboard bench for dcache_ctrl against a flat-memory reference view.
// Directed test-plan accesses first, then a reset-during-refill case, then random traffic.
module tb_dcache_ctrl;
    localparam int IDX_W      = 5;
    localparam int LINE_WORDS = 4;
    localparam int LW         = 32 * LINE_WORDS;
    localparam int LB         = 4 * LINE_WORDS;
    localparam int NL         = 1 << IDX_W;

    logic          clk_i = 1'b0;
    logic          rst_i, req_i, we_i, stall_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0]   addr_i, wdata_i, rdata_o, mem_addr_o;
    logic [LW-1:0] mem_wdata_o, mem_rdata_i;

    always #5 clk_i = ~clk_i;

    dcache_ctrl #(.IDX_W(IDX_W), .LINE_WORDS(LINE_WORDS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct { logic we; logic [31:0] addr; logic [LW-1:0] data; } txn_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] rdata; logic hit; } cmp_t;

    txn_t txn_q[$];
    cmp_t cmp_q[$];
    cmp_t mon_c;

    int n_cmp = 0, n_bad = 0;
    int lat_acc = 0, force_lat = -1, stall_cnt = 0, mcnt = 0;
    bit mem_auto = 0, mon_en = 0, mbusy = 0;

    logic [LW-1:0] bmem [logic [31:0]];
    logic [31:0]   rmem [logic [31:0]];
    bit            mv [NL];
    bit            md [NL];
    logic [31:0]   mt [NL];

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a >= 32'h40 && a < 32'h50) return 32'h1111_1111 * ((a - 32'h40) / 4 + 1);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic [LW-1:0] back_line(input logic [31:0] base);
        logic [LW-1:0] l;
        if (bmem.exists(base)) return bmem[base];
        for (int w = 0; w < LINE_WORDS; w++) l[32*w +: 32] = init_word(base + 32'(4 * w));
        return l;
    endfunction

    // Program-visible value of a word: last store, else what memory holds.
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [LW-1:0] l;
        if (rmem.exists(a)) return rmem[a];
        l = back_line(a - a % LB);
        return l[32 * ((a % LB) / 4) +: 32];
    endfunction

    // Memory responder: random (or forced) latency, ack pulse, line storage.
    always @(negedge clk_i) begin
        mem_ack_i = 1'b0;
        if (mem_auto && rst_i && mem_req_o) begin
            if (!mbusy) begin
                mbusy = 1;
                mcnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                lat_acc += mcnt + 1;
            end
            if (mcnt == 0) begin
                mbusy = 0;
                mem_ack_i = 1'b1;
                if (mem_we_o) bmem[mem_addr_o] = mem_wdata_o;
                else          mem_rdata_i = back_line(mem_addr_o);
            end else begin
                mcnt--;
            end
        end
    end

    // Monitor: checks memory requests against txn_q and completed accesses against cmp_q.
    always @(negedge clk_i) begin
        #1;
        if (mon_en) begin
            if (mem_req_o) begin
                if (txn_q.size() == 0) begin
                    chk("spurious_mem_req", mem_req_o, 1'b0);
                end else begin
                    chk("mem_we", mem_we_o, txn_q[0].we);
                    chk("mem_addr", mem_addr_o, txn_q[0].addr);
                    if (txn_q[0].we) chk("mem_wdata", mem_wdata_o, txn_q[0].data);
                    if (mem_ack_i) void'(txn_q.pop_front());
                end
            end
            if (!req_i) begin
                chk("idle_stall", stall_o, 1'b0);
                chk("idle_rdata", rdata_o, 32'h0);
                stall_cnt = 0;
            end else if (stall_o) begin
                stall_cnt++;
            end else if (cmp_q.size() == 0) begin
                chk("unexpected_completion", stall_o, 1'b1);
            end else begin
                mon_c = cmp_q.pop_front();
                chk("rdata", rdata_o, mon_c.rdata);
                chk("stall_cycles", stall_cnt, mon_c.hit ? 0 : 2 + lat_acc);
                stall_cnt = 0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with req_i low.
    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d, input bit drop);
        int idx, tag;
        bit hit, done;
        logic [31:0] vb;
        txn_t t;
        cmp_t c;
        idx = int'((a / LB) % NL);
        tag = int'(a / (LB * NL));
        hit = mv[idx] && (mt[idx] == tag);
        if (!hit) begin
            if (mv[idx] && md[idx]) begin
                vb = (mt[idx] * NL + idx) * LB;
                t.we = 1;
                t.addr = vb;
                for (int w = 0; w < LINE_WORDS; w++) t.data[32*w +: 32] = ref_rd(vb + 32'(4 * w));
                txn_q.push_back(t);
            end
            t.we = 0;
            t.addr = a - a % LB;
            t.data = '0;
            txn_q.push_back(t);
            mv[idx] = 1;
            mt[idx] = tag;
            md[idx] = 0;
        end
        drop = drop && !hit;
        if (!drop) begin
            c.we = we;
            c.addr = a;
            c.hit = hit;
            c.rdata = we ? 32'h0 : ref_rd(a);
            cmp_q.push_back(c);
            if (we) begin
                rmem[a] = d;
                md[idx] = 1;
            end
        end
        lat_acc = 0;
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
        if (drop) begin
            @(posedge clk_i);
            #1 req_i = 1'b0;
            for (int n = 0; n < 100 && txn_q.size() != 0; n++) @(posedge clk_i);
            if (txn_q.size() != 0) timeout("dropped_miss_drain");
            repeat (2) @(posedge clk_i);
            #1;
        end else begin
            done = 0;
            for (int n = 0; n < 100 && !done; n++) begin
                @(negedge clk_i);
                #2 done = !stall_o;
            end
            if (!done) timeout("access_complete");
            @(posedge clk_i);
            #1 req_i = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a;
        int gap;
        rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_rdata", rdata_o, 32'h0);
        rst_i = 1'b1;
        mem_auto = 1; mon_en = 1;
        @(posedge clk_i);
        #1;

        force_lat = 0;
        access(0, 32'h40, 32'h0, 0);
        force_lat = -1;
        access(1, 32'h48, 32'hDEAD_BEEF, 0);
        access(0, 32'h48, 32'h0, 0);
        access(0, 32'h44, 32'h0, 0);
        access(0, 32'h840, 32'h0, 0);
        force_lat = 5;
        access(0, 32'h2C0, 32'h0, 0);
        force_lat = -1;
        access(1, 32'h100, 32'hCAFE_F00D, 0);
        access(0, 32'h900, 32'h0, 0);

        // Reset while a refill is outstanding; the late ack must be ignored.
        mon_en = 0; mem_auto = 0;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h7000;
        for (int n = 0; n < 20 && !mem_req_o; n++) begin
            @(posedge clk_i);
            #1;
        end
        chk("pre_rst_mem_req", mem_req_o, 1'b1);
        #1 rst_i = 1'b0;
        #1;
        chk("arst_mem_req", mem_req_o, 1'b0);
        chk("arst_mem_we", mem_we_o, 1'b0);
        chk("arst_mem_addr", mem_addr_o, 32'h0);
        chk("arst_mem_wdata", mem_wdata_o, '0);
        req_i = 1'b0;
        #1;
        chk("arst_stall", stall_o, 1'b0);
        chk("arst_rdata", rdata_o, 32'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        #1 mem_ack_i = 1'b1; mem_rdata_i = '1;
        @(posedge clk_i);
        #1 mem_ack_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            #1;
            chk("late_ack_mem_req", mem_req_o, 1'b0);
            chk("late_ack_stall", stall_o, 1'b0);
        end
        for (int i = 0; i < NL; i++) begin
            mv[i] = 0;
            md[i] = 0;
        end
        rmem.delete();
        txn_q.delete();
        cmp_q.delete();
        mbusy = 0;
        mem_auto = 1; mon_en = 1;
        @(posedge clk_i);
        #1;
        access(0, 32'h40, 32'h0, 0);

        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) * NL + $urandom_range(0, 3)) * LB
                + $urandom_range(0, LINE_WORDS - 1) * 4;
            access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 7) == 0);
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clk_i);
                #1;
            end
        end

        repeat (4) @(posedge clk_i);
        #1;
        chk("txn_q_drained", 32'(txn_q.size()), 32'h0);
        chk("cmp_q_drained", 32'(cmp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
